// File: rtl/core_pkg.sv
// Shared definitions for the RV32 multi-cycle core: opcodes, sequencer phases,
// opcode classification and the default memory-wait limit.
package core_pkg;

  localparam int MEM_TIMEOUT_DEF = 16;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_R      = 7'b0110011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011
  } opcode_t;

  // Encoding is visible on the phase output, so values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_FAULT   = 3'd7
  } seq_state_t;

  // How an instruction proceeds after EXECUTE.
  typedef enum logic [1:0] {
    CLS_WB     = 2'd0,  // LUI, AUIPC, JAL, R-type: straight to writeback
    CLS_LOAD   = 2'd1,
    CLS_STORE  = 2'd2,
    CLS_BRANCH = 2'd3
  } op_class_t;

  typedef struct packed {
    logic      legal;
    op_class_t cls;
  } op_decode_t;

  function automatic op_decode_t decode_op(input logic [6:0] op);
    op_decode_t d;
    d.legal = 1'b1;
    d.cls   = CLS_WB;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_R: d.cls = CLS_WB;
      OP_LOAD:                        d.cls = CLS_LOAD;
      OP_STORE:                       d.cls = CLS_STORE;
      OP_BRANCH:                      d.cls = CLS_BRANCH;
      default:                        d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts wait cycles of an outstanding memory request and flags the cycle on
// which a further miss would exceed the allowed number of request cycles.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int CW = $clog2(MEM_TIMEOUT) + 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear has priority; otherwise count one per unanswered request cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)    cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + CW'(1);
  end

  // Wait-count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // After MEM_TIMEOUT-1 misses the current cycle is the last allowed request cycle.
  assign expired_o = (cnt_q == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/cycle_sequencer.sv
// Multi-cycle instruction sequencer: walks FETCH/DECODE/EXECUTE/MEM/WB,
// handshakes with memory, emits IR-load / PC-update / register-write strobes
// and counts retired instructions.
module cycle_sequencer
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_load,
  output logic             pc_clk,
  output logic             reg_we,
  output logic [2:0]       phase,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  seq_state_t       state_q, state_d;
  op_class_t        cls_q, cls_d;
  logic [CNT_W-1:0] retired_q;
  logic             expired;
  logic             tmr_clear, tmr_inc;
  seq_state_t       end_st;
  op_decode_t       dec;

  // Next state and strobes; strobes are decoded from state, with mem_ready
  // qualifying the completion strobes of the request states.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    ir_load = 1'b0;
    pc_clk  = 1'b0;
    reg_we  = 1'b0;
    fault   = 1'b0;
    dec     = decode_op(opcode);
    end_st  = run ? ST_FETCH : ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = ST_DECODE;
        end else if (expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        if (dec.legal) begin
          cls_d   = dec.cls;
          state_d = ST_EXECUTE;
        end else begin
          state_d = ST_FAULT;
        end
      end
      ST_EXECUTE: begin
        case (cls_q)
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_BRANCH: begin
            pc_clk  = 1'b1;
            state_d = end_st;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls_q == CLS_STORE);
        if (mem_ready) begin
          if (cls_q == CLS_STORE) begin
            pc_clk  = 1'b1;
            state_d = end_st;
          end else begin
            state_d = ST_WB;
          end
        end else if (expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_WB: begin
        reg_we  = 1'b1;
        pc_clk  = 1'b1;
        state_d = end_st;
      end
      ST_FAULT: begin
        fault = 1'b1;
      end
      default: state_d = ST_FAULT;
    endcase
  end

  // State and latched opcode class.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cls_q   <= CLS_WB;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  // Retired-instruction counter, one per PC update, wrapping silently.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       retired_q <= '0;
    else if (pc_clk) retired_q <= retired_q + CNT_W'(1);
  end

  // Outside a request, or when it completes, the wait count is held at zero so
  // every FETCH/MEM entry starts from a clean count.
  assign tmr_clear = !mem_req || mem_ready;
  assign tmr_inc   = mem_req && !mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk_i    (clock),
    .rst_i    (reset),
    .clear_i  (tmr_clear),
    .inc_i    (tmr_inc),
    .expired_o(expired)
  );

  assign phase   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: per-cycle phase/strobe vectors per scenario.
module tb_cycle_sequencer;

  localparam int CNT_W = 2;  // narrow counter so wrap-around is reachable

  logic             clock, reset, run, mem_ready;
  logic [6:0]       opcode;
  logic             mem_req, mem_we, ir_load, pc_clk, reg_we, fault;
  logic [2:0]       phase;
  logic [CNT_W-1:0] retired;

  int n_chk  = 0;
  int n_fail = 0;

  // {phase, mem_req, mem_we, ir_load, pc_clk, reg_we, fault}
  wire [8:0] obs = {phase, mem_req, mem_we, ir_load, pc_clk, reg_we, fault};

  localparam logic [8:0] E_IDLE = {3'd0, 6'b000000};
  localparam logic [8:0] E_FR   = {3'd1, 6'b101000};
  localparam logic [8:0] E_FW   = {3'd1, 6'b100000};
  localparam logic [8:0] E_DEC  = {3'd2, 6'b000000};
  localparam logic [8:0] E_EXE  = {3'd3, 6'b000000};
  localparam logic [8:0] E_EXB  = {3'd3, 6'b000100};
  localparam logic [8:0] E_ML   = {3'd4, 6'b100000};
  localparam logic [8:0] E_SW   = {3'd4, 6'b110000};
  localparam logic [8:0] E_SR   = {3'd4, 6'b110100};
  localparam logic [8:0] E_WB   = {3'd5, 6'b000110};
  localparam logic [8:0] E_FLT  = {3'd7, 6'b000001};

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_IL = 7'b0010011;

  cycle_sequencer #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .run      (run),
    .opcode   (opcode),
    .mem_ready(mem_ready),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .ir_load  (ir_load),
    .pc_clk   (pc_clk),
    .reg_we   (reg_we),
    .phase    (phase),
    .fault    (fault),
    .retired  (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle's inputs at the falling edge; outputs settle 1 time unit later.
  task automatic drive(input logic r, input logic [6:0] op, input logic rdy);
    @(negedge clock);
    run = r; opcode = op; mem_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode = OP_R;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; run = 1'b1; mem_ready = 1'b1; opcode = OP_R;
    #1;
    n_chk++;
    if (obs !== E_IDLE) begin n_fail++; $display("FAIL reset_outputs got=%b want=%b", obs, E_IDLE); end
    n_chk++;
    if (retired !== '0) begin n_fail++; $display("FAIL reset_retired got=%0d want=0", retired); end
    @(negedge clock);
    reset = 1'b0; run = 1'b0;
  endtask

  task automatic test_rtype();
    logic [8:0] ex [6] = '{E_IDLE, E_FR, E_DEC, E_EXE, E_WB, E_FR};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, OP_R, 1'b1);
      n_chk++;
      if (obs !== ex[i]) begin n_fail++; $display("FAIL rtype c%0d got=%b want=%b", i, obs, ex[i]); end
    end
    n_chk++;
    if (retired !== 2'd1) begin n_fail++; $display("FAIL rtype_retired got=%0d want=1", retired); end
  endtask

  task automatic test_load_wait();
    logic       rd [10] = '{1, 1, 1, 0, 0, 0, 0, 1, 0, 1};
    logic [8:0] ex [10] = '{E_IDLE, E_FR, E_DEC, E_EXE, E_ML, E_ML, E_ML, E_ML, E_WB, E_FR};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, OP_LD, rd[i]);
      n_chk++;
      if (obs !== ex[i]) begin n_fail++; $display("FAIL load c%0d got=%b want=%b", i, obs, ex[i]); end
    end
    n_chk++;
    if (retired !== 2'd1) begin n_fail++; $display("FAIL load_retired got=%0d want=1", retired); end
  endtask

  task automatic test_store();
    logic       rd [7] = '{0, 1, 0, 0, 0, 1, 1};
    logic [8:0] ex [7] = '{E_IDLE, E_FR, E_DEC, E_EXE, E_SW, E_SR, E_FR};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, OP_ST, rd[i]);
      n_chk++;
      if (obs !== ex[i]) begin n_fail++; $display("FAIL store c%0d got=%b want=%b", i, obs, ex[i]); end
    end
  endtask

  task automatic test_branch();
    logic [8:0] ex [5] = '{E_IDLE, E_FR, E_DEC, E_EXB, E_FR};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, OP_BR, 1'b1);
      n_chk++;
      if (obs !== ex[i]) begin n_fail++; $display("FAIL branch c%0d got=%b want=%b", i, obs, ex[i]); end
    end
  endtask

  task automatic test_timeout();
    // Fetch misses 16 request cycles -> FAULT, then terminal despite run/ready.
    do_reset();
    drive(1'b1, OP_R, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, OP_R, 1'b0);
      n_chk++;
      if (obs !== E_FW) begin n_fail++; $display("FAIL tmo_fetch c%0d got=%b want=%b", i, obs, E_FW); end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OP_R, 1'b1);
      n_chk++;
      if (obs !== E_FLT) begin n_fail++; $display("FAIL tmo_fault c%0d got=%b want=%b", i, obs, E_FLT); end
    end
    n_chk++;
    if (retired !== 2'd0) begin n_fail++; $display("FAIL tmo_retired got=%0d want=0", retired); end

    // Ready arrives on the 16th request cycle: accepted.
    do_reset();
    drive(1'b1, OP_R, 1'b0);
    for (int i = 1; i <= 15; i++) drive(1'b1, OP_R, 1'b0);
    drive(1'b1, OP_R, 1'b1);
    n_chk++;
    if (obs !== E_FR) begin n_fail++; $display("FAIL tmo_edge_accept got=%b want=%b", obs, E_FR); end
    drive(1'b1, OP_R, 1'b1);
    n_chk++;
    if (obs !== E_DEC) begin n_fail++; $display("FAIL tmo_edge_decode got=%b want=%b", obs, E_DEC); end

    // Wait count restarts on MEM entry: 5 fetch misses, then a full 16 MEM misses.
    do_reset();
    drive(1'b1, OP_LD, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, OP_LD, 1'b0);
    drive(1'b1, OP_LD, 1'b1);
    drive(1'b1, OP_LD, 1'b0);
    drive(1'b1, OP_LD, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, OP_LD, 1'b0);
      n_chk++;
      if (obs !== E_ML) begin n_fail++; $display("FAIL tmo_mem c%0d got=%b want=%b", i, obs, E_ML); end
    end
    drive(1'b1, OP_LD, 1'b0);
    n_chk++;
    if (obs !== E_FLT) begin n_fail++; $display("FAIL tmo_mem_fault got=%b want=%b", obs, E_FLT); end
  endtask

  task automatic test_illegal();
    logic [6:0] op [9] = '{OP_R, OP_R, OP_R, OP_R, OP_R, OP_IL, OP_IL, OP_IL, OP_IL};
    logic [8:0] ex [9] = '{E_IDLE, E_FR, E_DEC, E_EXE, E_WB, E_FR, E_DEC, E_FLT, E_FLT};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, op[i], 1'b1);
      n_chk++;
      if (obs !== ex[i]) begin n_fail++; $display("FAIL illegal c%0d got=%b want=%b", i, obs, ex[i]); end
    end
    n_chk++;
    if (retired !== 2'd1) begin n_fail++; $display("FAIL illegal_retired got=%0d want=1", retired); end
    // Asynchronous reset between clock edges.
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if (obs !== E_IDLE) begin n_fail++; $display("FAIL async_reset got=%b want=%b", obs, E_IDLE); end
    n_chk++;
    if (retired !== 2'd0) begin n_fail++; $display("FAIL async_reset_retired got=%0d want=0", retired); end
    @(negedge clock);
    reset = 1'b0; run = 1'b0;
  endtask

  task automatic test_run_drop();
    logic       rv [7] = '{1, 1, 1, 0, 0, 0, 0};
    logic [8:0] ex [7] = '{E_IDLE, E_FR, E_DEC, E_EXE, E_WB, E_IDLE, E_IDLE};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(rv[i], OP_R, 1'b1);
      n_chk++;
      if (obs !== ex[i]) begin n_fail++; $display("FAIL rundrop c%0d got=%b want=%b", i, obs, ex[i]); end
    end
    n_chk++;
    if (retired !== 2'd1) begin n_fail++; $display("FAIL rundrop_retired got=%0d want=1", retired); end
  endtask

  task automatic test_back_to_back();
    // branch(3) + load(5) + store(4) + branch(3), then next fetch; retired wraps 3 -> 0.
    logic [6:0] op [17] = '{OP_BR, OP_BR, OP_BR, OP_BR, OP_LD, OP_LD, OP_LD, OP_LD, OP_LD,
                            OP_ST, OP_ST, OP_ST, OP_ST, OP_BR, OP_BR, OP_BR, OP_R};
    logic [8:0] ex [17] = '{E_IDLE, E_FR, E_DEC, E_EXB, E_FR, E_DEC, E_EXE, E_ML, E_WB,
                            E_FR, E_DEC, E_EXE, E_SR, E_FR, E_DEC, E_EXB, E_FR};
    logic [1:0] rt [17] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 0};
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, op[i], 1'b1);
      n_chk++;
      if (obs !== ex[i]) begin n_fail++; $display("FAIL b2b c%0d got=%b want=%b", i, obs, ex[i]); end
      n_chk++;
      if (retired !== rt[i]) begin n_fail++; $display("FAIL b2b_retired c%0d got=%0d want=%0d", i, retired, rt[i]); end
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode = OP_R;
    test_reset();
    test_rtype();
    test_load_wait();
    test_store();
    test_branch();
    test_timeout();
    test_illegal();
    test_run_drop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
